// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: next-PC select encodings, the HALT
// instruction word and the instruction-fetch FSM states.
package mips_pkg;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JR     = 2'b11;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IF_IDLE   = 2'b00,
    IF_RUN    = 2'b01,
    IF_HALTED = 2'b10
  } if_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: asynchronous read, one synchronous write
// port used by the debug unit. Contents are deliberately not reset.
module instruction_memory #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC select, IDLE/RUN/HALTED control and the
// instruction memory that the debug unit loads while idle.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_Start,
  input  logic        i_Enable,
  input  logic        i_Stall,
  input  logic [1:0]  i_PCSrc,
  input  logic [31:0] i_Branch_Target,
  input  logic [31:0] i_Jump_Target,
  input  logic [31:0] i_JR_Target,
  input  logic        i_Load_We,
  input  logic [31:0] i_Load_Addr,
  input  logic [31:0] i_Load_Data,
  output logic [31:0] o_PC,
  output logic [31:0] o_PC_Plus4,
  output logic [31:0] o_Instruction,
  output logic        o_Halt,
  output logic [1:0]  o_State
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] mem_word;
  logic        mem_we;
  logic        is_halt_word;
  logic        advance;
  logic        unused_addr_bits;

  // The program may only be rewritten while the core is parked in IDLE.
  assign mem_we = i_Load_We & (state == IF_IDLE);

  instruction_memory #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_imem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(i_Load_Addr[ADDR_W+1:2]),
    .wdata(i_Load_Data),
    .raddr(pc[ADDR_W+1:2]),
    .rdata(mem_word)
  );

  assign unused_addr_bits = ^{i_Load_Addr[31:ADDR_W+2], i_Load_Addr[1:0]};

  assign pc_plus4     = pc + 32'd4;
  assign is_halt_word = (mem_word == HALT_WORD);
  assign advance      = i_Enable & ~i_Stall;

  always_comb begin
    next_pc = pc_plus4;
    unique case (i_PCSrc)
      PCSRC_SEQ:    next_pc = pc_plus4;
      PCSRC_BRANCH: next_pc = i_Branch_Target;
      PCSRC_JUMP:   next_pc = i_Jump_Target;
      PCSRC_JR:     next_pc = i_JR_Target;
      default:      next_pc = pc_plus4;
    endcase
  end

  // A HALT word freezes the PC; it only moves the FSM once the same
  // conditions that would let the PC advance are met.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IF_IDLE;
      pc    <= 32'd0;
    end else begin
      unique case (state)
        IF_IDLE: begin
          if (i_Start) state <= IF_RUN;
        end
        IF_RUN: begin
          if (is_halt_word) begin
            if (advance) state <= IF_HALTED;
          end else if (advance) begin
            pc <= next_pc;
          end
        end
        IF_HALTED: begin
          if (i_Start) begin
            state <= IF_IDLE;
            pc    <= 32'd0;
          end
        end
        default: begin
          state <= IF_IDLE;
          pc    <= 32'd0;
        end
      endcase
    end
  end

  assign o_PC          = pc;
  assign o_PC_Plus4    = pc_plus4;
  assign o_Instruction = (state == IF_RUN) ? mem_word : 32'h0;
  assign o_Halt        = (state == IF_HALTED) | ((state == IF_RUN) & is_halt_word);
  assign o_State       = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected outputs go into a scoreboard
// queue as each step is driven and are popped and checked at the falling edge.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_Start = 1'b0;
  logic        i_Enable = 1'b0;
  logic        i_Stall = 1'b0;
  logic [1:0]  i_PCSrc = 2'b00;
  logic [31:0] i_Branch_Target = 32'h0;
  logic [31:0] i_Jump_Target = 32'h0;
  logic [31:0] i_JR_Target = 32'h0;
  logic        i_Load_We = 1'b0;
  logic [31:0] i_Load_Addr = 32'h0;
  logic [31:0] i_Load_Data = 32'h0;
  logic [31:0] o_PC;
  logic [31:0] o_PC_Plus4;
  logic [31:0] o_Instruction;
  logic        o_Halt;
  logic [1:0]  o_State;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        halt;
    logic [1:0]  state;
  } exp_t;

  exp_t sb[$];

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;

  localparam logic [31:0] A0   = 32'h2001_0001;
  localparam logic [31:0] A1   = 32'h2002_0002;
  localparam logic [31:0] A2   = 32'h2003_0003;
  localparam logic [31:0] A3   = 32'h2004_0004;
  localparam logic [31:0] HW   = 32'hFFFF_FFFF;
  localparam logic [31:0] W20  = 32'h8C20_0020;
  localparam logic [31:0] W40  = 32'h1000_0040;
  localparam logic [31:0] W44  = 32'h1000_0044;
  localparam logic [31:0] W48  = 32'h1000_0048;
  localparam logic [31:0] W4C  = 32'h1000_004C;
  localparam logic [31:0] W80  = 32'h0800_0080;
  localparam logic [31:0] WFF  = 32'h3C00_00FF;

  instruction_fetch #(.MEM_DEPTH(256), .ADDR_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_Start        (i_Start),
    .i_Enable       (i_Enable),
    .i_Stall        (i_Stall),
    .i_PCSrc        (i_PCSrc),
    .i_Branch_Target(i_Branch_Target),
    .i_Jump_Target  (i_Jump_Target),
    .i_JR_Target    (i_JR_Target),
    .i_Load_We      (i_Load_We),
    .i_Load_Addr    (i_Load_Addr),
    .i_Load_Data    (i_Load_Data),
    .o_PC           (o_PC),
    .o_PC_Plus4     (o_PC_Plus4),
    .o_Instruction  (o_Instruction),
    .o_Halt         (o_Halt),
    .o_State        (o_State)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs at a falling edge and lets one rising edge pass.
  // Unselected targets carry the inverted value so a wrong mux leg shows up.
  task automatic applyStimulus(input logic start, input logic en, input logic stall,
                               input logic [1:0] src, input logic [31:0] tgt,
                               input logic we, input logic [31:0] addr,
                               input logic [31:0] data);
    i_Start         = start;
    i_Enable        = en;
    i_Stall         = stall;
    i_PCSrc         = src;
    i_Branch_Target = (src == 2'b01) ? tgt : ~tgt;
    i_Jump_Target   = (src == 2'b10) ? tgt : ~tgt;
    i_JR_Target     = (src == 2'b11) ? tgt : ~tgt;
    i_Load_We       = we;
    i_Load_Addr     = addr;
    i_Load_Data     = data;
    @(negedge clk);
  endtask

  task automatic compare(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: got size %0d, expected >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare({e.tag, ".pc"},    o_PC,          e.pc);
      compare({e.tag, ".pc4"},   o_PC_Plus4,    e.pc + 32'd4);
      compare({e.tag, ".instr"}, o_Instruction, e.instr);
      compare({e.tag, ".halt"},  {31'd0, o_Halt},  {31'd0, e.halt});
      compare({e.tag, ".state"}, {30'd0, o_State}, {30'd0, e.state});
    end
  endtask

  task automatic step(input string tag, input logic start, input logic en,
                      input logic stall, input logic [1:0] src, input logic [31:0] tgt,
                      input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] epc, input logic [31:0] einstr,
                      input logic ehalt, input logic [1:0] estate);
    exp_t e;
    e.tag = tag; e.pc = epc; e.instr = einstr; e.halt = ehalt; e.state = estate;
    sb.push_back(e);
    applyStimulus(start, en, stall, src, tgt, we, addr, data);
    checkOutput();
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [31:0] data);
    step(tag, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, addr, data, 32'h0, 32'h0, 1'b0, S_IDLE);
  endtask

  initial begin
    rst = 1'b1;
    step("reset", 0, 0, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, S_IDLE);
    rst = 1'b0;

    load("ld0",   32'h000, A0);
    load("ld1",   32'h004, A1);
    load("ld2",   32'h008, A2);
    load("ld3",   32'h00C, A3);
    load("ldH",   32'h010, HW);
    load("ld20",  32'h020, W20);
    load("ld40",  32'h040, W40);
    load("ld44",  32'h044, W44);
    load("ld48",  32'h048, W48);
    load("ld4C",  32'h04C, W4C);
    load("ld80",  32'h080, W80);

    // Start together with a write: both must take effect.
    step("start_we", 1, 1, 0, 2'b00, 32'h0, 1, 32'h3FC, WFF, 32'h00, A0, 0, S_RUN);
    step("seq4",     0, 1, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h04, A1, 0, S_RUN);
    step("seq8",     0, 1, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h08, A2, 0, S_RUN);
    step("branch",   0, 1, 0, 2'b01, 32'h40, 0, 32'h0, 32'h0, 32'h40, W40, 0, S_RUN);
    step("jump",     0, 1, 0, 2'b10, 32'h80, 0, 32'h0, 32'h0, 32'h80, W80, 0, S_RUN);
    step("jr",       0, 1, 0, 2'b11, 32'h0C, 0, 32'h0, 32'h0, 32'h0C, A3, 0, S_RUN);
    step("stall1",   0, 1, 1, 2'b01, 32'h40, 0, 32'h0, 32'h0, 32'h0C, A3, 0, S_RUN);
    step("stall2",   0, 1, 1, 2'b01, 32'h40, 0, 32'h0, 32'h0, 32'h0C, A3, 0, S_RUN);
    step("unstall",  0, 1, 0, 2'b01, 32'h40, 0, 32'h0, 32'h0, 32'h40, W40, 0, S_RUN);
    step("seq44",    0, 1, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h44, W44, 0, S_RUN);
    step("we_run",   0, 0, 0, 2'b00, 32'h0, 1, 32'h044, 32'hDEAD_BEEF, 32'h44, W44, 0, S_RUN);
    step("start_run",1, 0, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h44, W44, 0, S_RUN);
    step("pulse48",  0, 1, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h48, W48, 0, S_RUN);
    step("idle_a",   0, 0, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h48, W48, 0, S_RUN);
    step("idle_b",   0, 0, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h48, W48, 0, S_RUN);
    step("pulse4C",  0, 1, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h4C, W4C, 0, S_RUN);
    step("to_halt",  0, 1, 0, 2'b10, 32'h10, 0, 32'h0, 32'h0, 32'h10, HW, 1, S_RUN);
    step("halt_stl", 0, 1, 1, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h10, HW, 1, S_RUN);
    step("halt_dis", 0, 0, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h10, HW, 1, S_RUN);
    step("halted",   0, 1, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h10, 32'h0, 1, S_HALT);
    step("halt_hold",0, 1, 0, 2'b10, 32'h80, 0, 32'h0, 32'h0, 32'h10, 32'h0, 1, S_HALT);
    step("halt_idle",1, 1, 0, 2'b00, 32'h0, 1, 32'h000, 32'h0, 32'h00, 32'h0, 0, S_IDLE);
    step("rerun",    1, 1, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h00, A0, 0, S_RUN);
    step("jump20",   0, 1, 0, 2'b10, 32'h20, 0, 32'h0, 32'h0, 32'h20, W20, 0, S_RUN);

    rst = 1'b1;
    step("rst_mid",  0, 1, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h00, 32'h0, 0, S_IDLE);
    rst = 1'b0;
    step("restart",  1, 1, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h00, A0, 0, S_RUN);
    step("reseq4",   0, 1, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h04, A1, 0, S_RUN);
    step("wrap_idx", 0, 1, 0, 2'b11, 32'h400, 0, 32'h0, 32'h0, 32'h400, A0, 0, S_RUN);
    step("top_pc",   0, 1, 0, 2'b11, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, WFF, 0, S_RUN);
    step("pc_wrap",  0, 1, 0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 32'h00, A0, 0, S_RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
